// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin synchronisers, glitch filter, 11-bit deframer, E0/F0 prefix folding, show-ahead event FIFO.
// Optional build macro PS2_PARITY_EN enables odd-parity and stop-bit checking of each frame.
module ps2_rx_filter #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  // out only moves after in has disagreed with it for CYCLES consecutive clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      out <= 1'b1;
    end else if (in == out) begin
      cnt <= '0;
    end else if (cnt == CW'(CYCLES - 1)) begin
      cnt <= '0;
      out <= in;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 3,
  parameter int GLITCH_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8,
  localparam int AW            = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  input  logic          rd_en,
  output logic [9:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          frame_err,
  input  logic          clr_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_f, data_f, clk_f_d, fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '0;
      data_sync <= '0;
      clk_f_d   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_f_d   <= clk_f;
    end
  end

  // data gets the identical filter so it stays aligned with the filtered clock
  ps2_rx_filter #(.CYCLES(GLITCH_CYCLES)) u_clk_filt (
    .clk(clk), .rst(rst), .in(clk_sync[SYNC_STAGES-1]), .out(clk_f)
  );
  ps2_rx_filter #(.CYCLES(GLITCH_CYCLES)) u_data_filt (
    .clk(clk), .rst(rst), .in(data_sync[SYNC_STAGES-1]), .out(data_f)
  );

  assign fall = clk_f_d & ~clk_f;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_bit;
  logic [TW-1:0] to_cnt;
  logic          expand, brk;
  logic          push_q;
  logic [9:0]    push_data;
  logic          frame_ok, abort, err_set;

`ifdef PS2_PARITY_EN
  assign frame_ok = (^{shreg, parity_bit}) & data_f;
`else
  logic unused_parity;
  assign unused_parity = parity_bit;
  assign frame_ok      = 1'b1;
`endif

  assign abort   = !fall && (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err_set = abort | (fall && (state == STOP) && !frame_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      expand     <= 1'b0;
      brk        <= 1'b0;
      push_q     <= 1'b0;
      push_data  <= '0;
    end else begin
      push_q <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          IDLE: if (!data_f) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg <= {data_f, shreg[7:1]};
            if (bit_cnt == 3'd7) state <= PARITY;
            else bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: begin
            parity_bit <= data_f;
            state      <= STOP;
          end
          default: begin
            state <= IDLE;
            if (!frame_ok) begin
              expand <= 1'b0;
              brk    <= 1'b0;
            end else if (shreg == 8'hE0) begin
              expand <= 1'b1;
            end else if (shreg == 8'hF0) begin
              brk <= 1'b1;
            end else begin
              push_q    <= 1'b1;
              push_data <= {expand, brk, shreg};
              expand    <= 1'b0;
              brk       <= 1'b0;
            end
          end
        endcase
      end else if (state == IDLE) begin
        to_cnt <= '0;
      end else if (abort) begin
        state  <= IDLE;
        to_cnt <= '0;
        expand <= 1'b0;
        brk    <= 1'b0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd, ovf_set;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_rd   = rd_en & ~empty;
  // a full FIFO still accepts a push when the same cycle pops
  assign do_wr   = push_q & (~full | rd_en);
  assign ovf_set = push_q & full & ~rd_en;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // a set event in the same cycle as clr_err keeps the flag high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (err_set)      frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames, hand-computed key events, one summary line.
module tb_ps2_rx_fifo;
  localparam int FIFO_DEPTH = 4;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [9:0]    dout;
  logic          empty, full, overflow, frame_err;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_pass = 0;

  ps2_rx_fifo #(
    .SYNC_STAGES(2), .GLITCH_CYCLES(4), .TIMEOUT_CYCLES(200), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .count(count), .overflow(overflow),
    .frame_err(frame_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 40 clk per bit: data set while high, 20 clk low, 20 clk high
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    idle(10);
    ps2_clk = 1'b0;
    idle(20);
    ps2_clk = 1'b1;
    if (glitch) begin
      idle(8);
      ps2_clk = 1'b0;
      idle(2);
      ps2_clk = 1'b1;
    end else begin
      idle(10);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input int nbits, input bit glitch);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i], glitch);
    ps2_data = 1'b1;
    idle(10);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
    idle(1);
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(1);
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    idle(3);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);

    // single make code
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    check("t1_dout", 32'(dout), 32'h01C);
    check("t1_count", 32'(count), 32'd1);
    check("t1_empty", 32'(empty), 32'd0);
    pop();
    check("t1_pop_empty", 32'(empty), 32'd1);

    // extended break, then flags must be clear for the next key
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    check("t2_prefix_nopush", 32'(empty), 32'd1);
    send_frame(8'h75, 1'b0, 11, 1'b0);
    check("t2_dout", 32'(dout), 32'h375);
    check("t2_count", 32'(count), 32'd1);
    pop();
    send_frame(8'h29, 1'b0, 11, 1'b0);
    check("t2_next_dout", 32'(dout), 32'h029);
    pop();

    // fill past capacity
    for (int i = 0; i < 5; i++) send_frame(8'h16, 1'b0, 11, 1'b0);
    check("t3_count", 32'(count), 32'd4);
    check("t3_full", 32'(full), 32'd1);
    check("t3_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_pop%0d_dout", i), 32'(dout), 32'h016);
      pop();
    end
    check("t3_drained", 32'(empty), 32'd1);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);
    clear_errs();
    check("t3_ovf_clr", 32'(overflow), 32'd0);

    // truncated frame: start + 4 data bits, then silence
    send_frame(8'h1C, 1'b0, 5, 1'b0);
    idle(140);
    check("t4_before_timeout", 32'(frame_err), 32'd0);
    idle(100);
    check("t4_frame_err", 32'(frame_err), 32'd1);
    check("t4_nopush", 32'(empty), 32'd1);
    clear_errs();
    check("t4_err_clr", 32'(frame_err), 32'd0);
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    check("t4_recover_dout", 32'(dout), 32'h01C);
    check("t4_recover_count", 32'(count), 32'd1);
    pop();

    // short clock glitches in every high phase
    send_frame(8'h5A, 1'b0, 11, 1'b1);
    check("t5_dout", 32'(dout), 32'h05A);
    check("t5_count", 32'(count), 32'd1);
    check("t5_no_err", 32'(frame_err), 32'd0);
    pop();

    // wrong parity
    send_frame(8'h1C, 1'b1, 11, 1'b0);
`ifdef PS2_PARITY_EN
    check("t6_nopush", 32'(empty), 32'd1);
    check("t6_frame_err", 32'(frame_err), 32'd1);
`else
    check("t6_dout", 32'(dout), 32'h01C);
    check("t6_frame_err", 32'(frame_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
